// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared types and constants for the CDB arbiter
package cdb_arbiter_pkg;

  localparam int CDB_ALU   = 0;
  localparam int CDB_BRALU = 1;
  localparam int CDB_MUL   = 2;
  localparam int CDB_DIV   = 3;
  localparam int CDB_MEM   = 4;

  localparam int DEF_NUM_REQ = CDB_MEM + 1;
  localparam int ROB_IX_W    = 3;
  localparam int DEST_W      = 5;

  typedef struct packed {
    logic [31:0]         value;
    logic [ROB_IX_W-1:0] rob_ix;
    logic [DEST_W-1:0]   dest;
  } cdb_entry_t;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU request side and CDB broadcast side of the arbiter
interface cdb_arbiter_if #(
  parameter int NUM_REQ = cdb_arbiter_pkg::DEF_NUM_REQ
);
  import cdb_arbiter_pkg::*;

  localparam int SRC_W = src_width(NUM_REQ);

  logic                               flush_in;
  logic [NUM_REQ-1:0]                 req_valid_in;
  logic [NUM_REQ-1:0][31:0]           req_value_in;
  logic [NUM_REQ-1:0][ROB_IX_W-1:0]   req_rob_ix_in;
  logic [NUM_REQ-1:0][DEST_W-1:0]     req_dest_in;
  logic [NUM_REQ-1:0]                 req_read_out;
  logic                               cdb_valid_out;
  logic [31:0]                        cdb_value_out;
  logic [ROB_IX_W-1:0]                cdb_rob_ix_out;
  logic [DEST_W-1:0]                  cdb_dest_out;
  logic [SRC_W-1:0]                   cdb_src_out;
  logic [NUM_REQ-1:0]                 slot_full_out;

  modport master (
    output flush_in, req_valid_in, req_value_in, req_rob_ix_in, req_dest_in,
    input  req_read_out, cdb_valid_out, cdb_value_out, cdb_rob_ix_out,
    input  cdb_dest_out, cdb_src_out, slot_full_out
  );

  modport slave (
    input  flush_in, req_valid_in, req_value_in, req_rob_ix_in, req_dest_in,
    output req_read_out, cdb_valid_out, cdb_value_out, cdb_rob_ix_out,
    output cdb_dest_out, cdb_src_out, slot_full_out
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with its own rotating pointer
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N    = DEF_NUM_REQ,
  parameter int IX_W = src_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [IX_W-1:0] grant_ix,
  output logic            grant_any
);

  localparam int SW = IX_W + 1;

  logic [IX_W-1:0] ptr;
  logic [SW-1:0]   sum;
  logic [IX_W-1:0] cand;

  // First requester at or after the pointer, wrapping at N-1.
  always_comb begin
    grant     = '0;
    grant_ix  = '0;
    grant_any = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N)) begin
        sum = sum - SW'(N);
      end
      cand = sum[IX_W-1:0];
      if (en && !grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_ix    = cand;
        grant_any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_ix == IX_W'(N - 1)) ? '0 : grant_ix + 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-FU result slots arbitrated onto one registered CDB
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  cdb_arbiter_if.slave   bus
);

  localparam int SRC_W = src_width(NUM_REQ);

  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;
  logic [SRC_W-1:0]   grant_ix;
  logic               grant_any;
  cdb_entry_t         slot [NUM_REQ];
  cdb_entry_t         cdb_q;
  logic               cdb_valid_q;
  logic [SRC_W-1:0]   cdb_src_q;

  // Arbitration sees only registered occupancy; flush suppresses any grant.
  rr_arbiter #(.N(NUM_REQ), .IX_W(SRC_W)) u_rr (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .en        (!bus.flush_in),
    .req       (full),
    .grant     (grant),
    .grant_ix  (grant_ix),
    .grant_any (grant_any)
  );

  // A slot being granted this cycle can take a new result at the same edge.
  always_comb begin
    accept = {NUM_REQ{rst_n_in && !bus.flush_in}} & bus.req_valid_in & (~full | grant);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      full        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
      cdb_src_q   <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        slot[k] <= '0;
      end
    end else if (bus.flush_in) begin
      full        <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (accept[k]) begin
          slot[k] <= '{value:  bus.req_value_in[k],
                       rob_ix: bus.req_rob_ix_in[k],
                       dest:   bus.req_dest_in[k]};
          full[k] <= 1'b1;
        end else if (grant[k]) begin
          full[k] <= 1'b0;
        end
      end
      cdb_valid_q <= grant_any;
      if (grant_any) begin
        cdb_q     <= slot[grant_ix];
        cdb_src_q <= grant_ix;
      end
    end
  end

  assign bus.req_read_out   = accept;
  assign bus.cdb_valid_out  = cdb_valid_q;
  assign bus.cdb_value_out  = cdb_q.value;
  assign bus.cdb_rob_ix_out = cdb_q.rob_ix;
  assign bus.cdb_dest_out   = cdb_q.dest;
  assign bus.cdb_src_out    = cdb_src_q;
  assign bus.slot_full_out  = full;

endmodule
